pe_config_loader: RTL

- Sequencer that loads a PE tile's serial configuration chain from a stream of 32-bit bitstream words.
- The chain is the ALU2/MEM config cells plus the FULLYCONN crossbar config cells, joined by the config_in/config_out daisy chain.
- Clears the chain, shifts in exactly CHAIN_LEN bits, then optionally runs a recirculating read-back pass that verifies the chain contents without disturbing them.
- Sits between the fabric-level bitstream DMA and one PE tile; cfg_shift is used as the clock enable for the tile's config_clk domain.

---
 rtl/pe_cfg_pkg.sv | 30 +++
 rtl/pe_cfg_serializer.sv | 62 ++++++
 rtl/pe_config_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pe_cfg_pkg.sv
// pe_cfg_pkg: definitions shared by the PE configuration loader and its
// word serializer.
//   state_e           - loader sequencing states
//   WORD_W            - bitstream word width
//   CHAIN_LEN_DEFAULT - config bits in one PE tile chain
//   idx_width()       - index width for an n-entry vector (never below 1)
package pe_cfg_pkg;

    localparam int WORD_W = 32;

    // Chain order: ALU2 cells, MEM cell, FULLYCONN_2X1, FULLYCONN_4X4.
    localparam int ALU2_CFG_W    = 4;
    localparam int MEM_CFG_W     = 1;
    localparam int FC2X1_CFG_W   = 1;
    localparam int FC4X4_CFG_W   = 8;
    localparam int CHAIN_LEN_DEFAULT = ALU2_CFG_W + MEM_CFG_W + FC2X1_CFG_W + FC4X4_CFG_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_cfg_serializer.sv
// pe_cfg_serializer: one-word buffer that accepts a bitstream word over a
// ready/valid handshake and hands it out LSB first, one bit per shift.
//   clk_i, reset_i  - clock, synchronous active-high reset
//   flush_i         - drop any remaining bits (unused tail of the last word)
//   fetch_en_i      - loader is in a state that may accept words
//   word_i          - bitstream word
//   word_valid_i    - word_i is valid
//   shift_i         - consume the current bit
//   word_ready_o    - word accepted this cycle when word_valid_i is high
//   bit_o           - current bit (buffer LSB)
//   empty_o         - no bits left in the buffer
module pe_cfg_serializer #(
    parameter int W = pe_cfg_pkg::WORD_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  logic         fetch_en_i,
    input  logic [W-1:0] word_i,
    input  logic         word_valid_i,
    input  logic         shift_i,
    output logic         word_ready_o,
    output logic         bit_o,
    output logic         empty_o
);
    import pe_cfg_pkg::*;

    localparam int REM_W = $clog2(W + 1);

    logic [W-1:0]     buf_q, buf_d;
    logic [REM_W-1:0] rem_q, rem_d;

    assign empty_o      = (rem_q == '0);
    assign word_ready_o = fetch_en_i && empty_o;
    assign bit_o        = buf_q[0];

    always_comb begin
        buf_d = buf_q;
        rem_d = rem_q;
        if (flush_i) begin
            buf_d = '0;
            rem_d = '0;
        end else if (word_ready_o && word_valid_i) begin
            buf_d = word_i;
            rem_d = REM_W'(W);
        end else if (shift_i && !empty_o) begin
            buf_d = buf_q >> 1;
            rem_d = rem_q - REM_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_q <= '0;
            rem_q <= '0;
        end else begin
            buf_q <= buf_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/pe_config_loader.sv
// pe_config_loader: clears a PE tile config chain, shifts in CHAIN_LEN bits
// from the bitstream, then optionally recirculates the chain once to check
// it against a shadow copy of what was loaded.
//   clk_i, reset_i   - clock, synchronous active-high reset
//   start_i          - begin a load (only honoured in IDLE)
//   word_in_i        - bitstream word, with word_valid_i / word_ready_o
//   cfg_reset_o      - chain config_reset
//   cfg_shift_o      - chain shift strobe (config_clk enable)
//   cfg_data_o       - chain config_in
//   cfg_readback_i   - chain config_out
//   busy_o, done_o   - not idle / one-cycle end-of-load pulse
//   error_o          - sticky read-back mismatch
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_CLEAR  | one cycle of cfg_reset on the chain
// ST_LOAD   | fetch a word when the buffer is empty, else shift one bit
// ST_VERIFY | recirculate the chain, compare each bit with the shadow
// ST_DONE   | one-cycle done pulse
module pe_config_loader #(
    parameter int CHAIN_LEN = pe_cfg_pkg::CHAIN_LEN_DEFAULT,
    parameter int WORD_W    = pe_cfg_pkg::WORD_W,
    parameter int VERIFY    = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_in_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic              cfg_reset_o,
    output logic              cfg_shift_o,
    output logic              cfg_data_o,
    input  logic              cfg_readback_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);
    import pe_cfg_pkg::*;

    localparam int               CNT_W    = idx_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    state_e               state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]     vfy_cnt_q;
    logic [CHAIN_LEN-1:0] shadow_q;
    logic                 error_q;

    logic ser_bit;
    logic ser_empty;
    logic load_shift;
    logic last_bit;
    logic ser_flush;

    assign load_shift = (state_q == ST_LOAD) && !ser_empty;
    assign last_bit   = load_shift && (bit_cnt_q == LAST_IDX);
    // The tail of the final word must not be carried into the next load.
    assign ser_flush  = (state_q == ST_CLEAR) || last_bit;

    pe_cfg_serializer #(
        .W(WORD_W)
    ) u_ser (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (ser_flush),
        .fetch_en_i   (state_q == ST_LOAD),
        .word_i       (word_in_i),
        .word_valid_i (word_valid_i),
        .shift_i      (load_shift),
        .word_ready_o (word_ready_o),
        .bit_o        (ser_bit),
        .empty_o      (ser_empty)
    );

    assign cfg_reset_o = (state_q == ST_CLEAR);
    assign cfg_shift_o = load_shift || (state_q == ST_VERIFY);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign error_o     = error_q;

    // During verify the chain output is fed straight back in, so after
    // CHAIN_LEN strobes the chain holds exactly what was loaded.
    always_comb begin
        cfg_data_o = 1'b0;
        if (state_q == ST_LOAD) begin
            cfg_data_o = ser_bit;
        end else if (state_q == ST_VERIFY) begin
            cfg_data_o = cfg_readback_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            vfy_cnt_q <= '0;
            shadow_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q   <= ST_CLEAR;
                        error_q   <= 1'b0;
                        bit_cnt_q <= '0;
                        vfy_cnt_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (load_shift) begin
                        shadow_q[bit_cnt_q] <= ser_bit;
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            state_q   <= (VERIFY != 0) ? ST_VERIFY : ST_DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_VERIFY: begin
                    if (cfg_readback_i != shadow_q[vfy_cnt_q]) begin
                        error_q <= 1'b1;
                    end
                    if (vfy_cnt_q == LAST_IDX) begin
                        vfy_cnt_q <= '0;
                        state_q   <= ST_DONE;
                    end else begin
                        vfy_cnt_q <= vfy_cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
